// File: rtl/scarv_cop_insn_queue.sv
// scarv_cop_insn_queue: instruction queue feeding the ISE instruction decoder.
// Buffers {instruction, rs1, sequence tag} in a DEPTH-entry circular FIFO.
// The head entry is exposed to the decoder and popped by dispatch on valid && ready.
// Optional feature macro: SCARV_COP_IQ_BYPASS_EN. When it is defined, an
// instruction offered to an empty queue appears on the head outputs in the
// same cycle.
module scarv_cop_insn_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     g_clk,
  input  logic                     g_reset,
  input  logic                     cpu_insn_req,
  output logic                     cpu_insn_ack,
  input  logic [31:0]              cpu_insn_enc,
  input  logic [31:0]              cpu_rs1,
  input  logic                     flush,
  output logic [31:0]              id_encoded,
  output logic [31:0]              iq_rs1,
  output logic [TAG_W-1:0]         iq_tag,
  output logic                     iq_valid,
  input  logic                     iq_ready,
  output logic [$clog2(DEPTH):0]   iq_count,
  output logic                     iq_full,
  output logic                     iq_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Control state
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [TAG_W-1:0] next_tag_q, next_tag_d;

  // Entry storage; it is never reset
  logic [31:0]      enc_mem [DEPTH];
  logic [31:0]      rs1_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic push;
  logic bypass;
  logic bypass_take;
  logic wr_en;
  logic rd_en;

  // Handshake decode: accept, bypass, write and read enables
  always_comb begin
    iq_full      = (count_q == CntW'(DEPTH));
    iq_empty     = (count_q == '0);
    cpu_insn_ack = !g_reset && !flush && !iq_full;
    push         = cpu_insn_req && cpu_insn_ack;
`ifdef SCARV_COP_IQ_BYPASS_EN
    bypass       = push && iq_empty;
`else
    bypass       = 1'b0;
`endif
    iq_valid     = !g_reset && (!iq_empty || bypass);
    // A bypassed instruction consumed in the same cycle is never written.
    bypass_take  = bypass && iq_ready;
    wr_en        = push && !bypass_take;
    rd_en        = !g_reset && !iq_empty && iq_ready;
    iq_count     = count_q;
  end

  // Head outputs, forced to zero when nothing is valid
  always_comb begin
    id_encoded = '0;
    iq_rs1     = '0;
    iq_tag     = '0;
    if (bypass) begin
      id_encoded = cpu_insn_enc;
      iq_rs1     = cpu_rs1;
      iq_tag     = next_tag_q;
    end else if (iq_valid) begin
      id_encoded = enc_mem[rd_ptr_q];
      iq_rs1     = rs1_mem[rd_ptr_q];
      iq_tag     = tag_mem[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy and tag counter
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    next_tag_d = next_tag_q;
    if (flush) begin
      // ack is low during flush, so wr_ptr cannot move this cycle.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push)  next_tag_d = next_tag_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      next_tag_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      next_tag_q <= next_tag_d;
    end
  end

  // Entry write on push
  always_ff @(posedge g_clk) begin
    if (wr_en) begin
      enc_mem[wr_ptr_q] <= cpu_insn_enc;
      rs1_mem[wr_ptr_q] <= cpu_rs1;
      tag_mem[wr_ptr_q] <= next_tag_q;
    end
  end

endmodule
